ps2_keyboard_receiver: RTL

PS/2 keyboard front end for the tic-tac-toe board controller.
- Samples the raw PS/2 clock and data lines, deframes 11-bit device-to-host frames and filters out break and extended prefixes.
- Delivers each make scancode as iData plus a flag to the downstream board/cursor detector.
- The detector acts on the falling edge of the flag.

---
 rtl/ps2_keyboard_receiver_pkg.sv | 34 +++
 rtl/ps2_keyboard_receiver_sync_edge.sv | 37 +++
 rtl/ps2_keyboard_receiver.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_keyboard_receiver_pkg.sv
// ============================================================================
//  Module      : ps2_keyboard_receiver_pkg
//  Description : Shared scancodes, prefix bytes, FSM encoding and parity helper
//                for the PS/2 keyboard receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_keyboard_receiver_pkg;

    localparam logic [7:0] SC_W         = 8'h1D;
    localparam logic [7:0] SC_A         = 8'h1C;
    localparam logic [7:0] SC_S         = 8'h1B;
    localparam logic [7:0] SC_D         = 8'h23;
    localparam logic [7:0] SC_R         = 8'h2D;
    localparam logic [7:0] SC_ENTER     = 8'h5A;
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] EXT_PREFIX   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    // Odd parity: data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_keyboard_receiver_sync_edge.sv
// ============================================================================
//  Module      : ps2_sync_edge
//  Description : 2-FF synchronizer for the raw PS/2 clock plus falling-edge
//                detector on the synchronized level.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Reset to the idle-high level so leaving reset never fakes an edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign fall_o = prev_q & ~sync_q;

endmodule

`default_nettype wire

// File: rtl/ps2_keyboard_receiver.sv
// ============================================================================
//  Module      : ps2_keyboard_receiver
//  Description : PS/2 device-to-host deframer delivering make scancodes with a
//                self-clearing flag. Optional PS2_PARITY_CHECK_EN adds odd
//                parity checking and the oParityError port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_keyboard_receiver
    import ps2_keyboard_receiver_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 5000,
    parameter int FLAG_HOLD_CYCLES = 1000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2Clock,
    input  logic       iPS2Data,
    input  logic       iKeyboardReset,
    output logic [7:0] oData,
    output logic       oKeyboardFlag,
    output logic       oFrameError
`ifdef PS2_PARITY_CHECK_EN
    ,
    output logic       oParityError
`endif
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(FLAG_HOLD_CYCLES + 1);

    logic          w_fall;
    logic          data_meta_q;
    logic          data_sync_q;

    ps2_state_e    state_q,     state_d;
    logic [2:0]    bit_cnt_q,   bit_cnt_d;
    logic [7:0]    shift_q,     shift_d;
    logic          parity_q,    parity_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic          break_q,     break_d;
    logic [7:0]    data_q,      data_d;
    logic          flag_q,      flag_d;
    logic [HW-1:0] hold_q,      hold_d;
    logic          pend_q,      pend_d;
    logic [7:0]    pend_byte_q, pend_byte_d;
    logic          ferr_q,      ferr_d;
    logic          perr_q,      perr_d;

    logic          w_valid;
    logic          w_deliver;
    logic          w_timeout;

    ps2_sync_edge u_clk_sync (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .async_i (iPS2Clock),
        .fall_o  (w_fall)
    );

    // Data is delayed by the same two stages as the clock so both line up
    // on the cycle the falling edge is flagged.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= iPS2Data;
            data_sync_q <= data_meta_q;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            parity_q    <= 1'b0;
            timer_q     <= '0;
            break_q     <= 1'b0;
            data_q      <= 8'h00;
            flag_q      <= 1'b0;
            hold_q      <= '0;
            pend_q      <= 1'b0;
            pend_byte_q <= 8'h00;
            ferr_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            parity_q    <= parity_d;
            timer_q     <= timer_d;
            break_q     <= break_d;
            data_q      <= data_d;
            flag_q      <= flag_d;
            hold_q      <= hold_d;
            pend_q      <= pend_d;
            pend_byte_q <= pend_byte_d;
            ferr_q      <= ferr_d;
            perr_q      <= perr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        parity_d    = parity_q;
        break_d     = break_q;
        data_d      = data_q;
        flag_d      = flag_q;
        hold_d      = hold_q;
        pend_d      = pend_q;
        pend_byte_d = pend_byte_q;
        ferr_d      = 1'b0;
        perr_d      = 1'b0;
        w_valid     = 1'b0;
        w_deliver   = 1'b0;

        if (w_fall || state_q == ST_IDLE) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
        w_timeout = (state_q != ST_IDLE) && !w_fall && (timer_q == TW'(TIMEOUT_CYCLES - 1));

        if (w_timeout) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
            timer_d = '0;
        end else if (w_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end
                ST_DATA: begin
                    shift_d   = {data_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    parity_d = data_sync_q;
                    state_d  = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!data_sync_q) begin
                        ferr_d = 1'b1;
                    end else begin
`ifdef PS2_PARITY_CHECK_EN
                        if (!odd_parity_ok(shift_q, parity_q)) begin
                            perr_d = 1'b1;
                        end else begin
                            w_valid = 1'b1;
                        end
`else
                        w_valid = 1'b1;
`endif
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        if (w_valid) begin
            if (shift_q == BREAK_PREFIX) begin
                break_d = 1'b1;
            end else if (shift_q == EXT_PREFIX) begin
                break_d = break_q;
            end else if (break_q) begin
                break_d = 1'b0;
            end else begin
                w_deliver = 1'b1;
            end
        end

        if (flag_q) begin
            hold_d = hold_q + 1'b1;
        end
        if (pend_q) begin
            pend_d = 1'b0;
            flag_d = 1'b1;
            data_d = pend_byte_q;
            hold_d = '0;
        end else if (flag_q && (iKeyboardReset || hold_q == HW'(FLAG_HOLD_CYCLES - 1))) begin
            flag_d = 1'b0;
            hold_d = '0;
        end

        // A code arriving while the flag is up forces a one-cycle low so the
        // consumer's falling-edge detector fires for every code.
        if (w_deliver) begin
            if (flag_q) begin
                flag_d      = 1'b0;
                pend_d      = 1'b1;
                pend_byte_d = shift_q;
            end else begin
                flag_d = 1'b1;
                data_d = shift_q;
                hold_d = '0;
            end
        end
    end

    assign oData         = data_q;
    assign oKeyboardFlag = flag_q;
    assign oFrameError   = ferr_q;

`ifdef PS2_PARITY_CHECK_EN
    assign oParityError  = perr_q;
`else
    logic unused_parity;
    assign unused_parity = parity_q ^ perr_q;
`endif

endmodule

`default_nettype wire
